// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Purpose  : Synchronous FIFO controller that sits directly in front of a
//            dual-port RAM. It keeps the write/read pointers, the occupancy
//            count and the status flags. It drives RAM port 0 for writes and
//            RAM port 1 for registered reads, and it returns the RAM read data
//            to the client with a one-cycle valid strobe.
// Ports    :
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   wr_en, wr_data          push request and push data
//   rd_en                   pop request
//   rd_data, rd_valid       popped word (pass-through of ram_data_1) + strobe
//   flush                   synchronous clear of pointers, count, rd_valid
//   clr_flags               synchronous clear of overflow/underflow
//   full, empty             count == DEPTH / count == 0
//   almost_full             count >= DEPTH - AF_MARGIN
//   almost_empty            count <= AE_MARGIN
//   count                   stored words, 0..DEPTH
//   overflow, underflow     sticky rejected-push / rejected-pop flags
//   ram_*_0                 RAM write port (address, enable, dir=1, data)
//   ram_*_1                 RAM read port (address, enable, dir=0), data in
//   ram_full                copy of full for the RAM
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  flush,
  input  logic                  clr_flags,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_address_0,
  output logic                  ram_chip_enable_0,
  output logic                  ram_write_read_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic [ADDR_WIDTH-1:0] ram_address_1,
  output logic                  ram_chip_enable_1,
  output logic                  ram_write_read_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1,
  output logic                  ram_full
);

  localparam logic [ADDR_WIDTH:0] C_DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] C_ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] C_AF_LEVEL = C_DEPTH - (ADDR_WIDTH+1)'(AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] C_AE_LEVEL = (ADDR_WIDTH+1)'(AE_MARGIN);

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q,  count_d;
  logic                rd_valid_q, rd_valid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic w_pop_ok, w_push_ok;
  logic w_pop_acc, w_push_acc;
  logic w_push_rej, w_pop_rej;

  // Status flags come only from the registered count, so there is no
  // combinational path from the request inputs to the flags.
  assign full         = (count_q == C_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= C_AF_LEVEL);
  assign almost_empty = (count_q <= C_AE_LEVEL);
  assign ram_full     = full;
  assign count        = count_q;

  // A push into a full FIFO is legal when a pop frees a slot in the same
  // cycle. Flush masks both requests and suppresses error reporting.
  assign w_pop_ok   = rd_en & ~empty;
  assign w_push_ok  = wr_en & (~full | w_pop_ok);
  assign w_pop_acc  = w_pop_ok  & ~flush;
  assign w_push_acc = w_push_ok & ~flush;
  assign w_push_rej = wr_en & ~w_push_ok & ~flush;
  assign w_pop_rej  = rd_en & empty      & ~flush;

  // RAM drive. When full with push+pop, both ports target the same address;
  // the RAM returns the old word (the correct pop data) and stores the new.
  assign ram_chip_enable_0 = w_push_acc;
  assign ram_address_0     = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_write_read_0  = 1'b1;
  assign ram_data_0        = wr_data;
  assign ram_chip_enable_1 = w_pop_acc;
  assign ram_address_1     = rd_ptr_q[ADDR_WIDTH-1:0];
  assign ram_write_read_1  = 1'b0;

  // The RAM read port is registered, so its output lines up with rd_valid.
  assign rd_data   = ram_data_1;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = w_pop_acc;
    // A new error in the same cycle as clr_flags keeps the flag set.
    overflow_d  = w_push_rej | (overflow_q  & ~clr_flags);
    underflow_d = w_pop_rej  | (underflow_q & ~clr_flags);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push_acc) wr_ptr_d = wr_ptr_q + C_ONE;
      if (w_pop_acc)  rd_ptr_d = rd_ptr_q + C_ONE;
      case ({w_push_acc, w_pop_acc})
        2'b10:   count_d = count_q + C_ONE;
        2'b01:   count_d = count_q - C_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl
// Purpose  : Self-checking bench for fifo_ctrl with DEPTH 8. A behavioural
//            RAM model sits on the two RAM ports; a queue model of the FIFO
//            predicts acceptance, flags and count, and popped words are
//            queued as expected read data and compared when rd_valid rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en, flush, clr_flags;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;
  logic [AW-1:0] ram_address_0, ram_address_1;
  logic          ram_chip_enable_0, ram_write_read_0;
  logic          ram_chip_enable_1, ram_write_read_1;
  logic [DW-1:0] ram_data_0;
  logic [DW-1:0] ram_data_1;
  logic          ram_full;

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .flush(flush), .clr_flags(clr_flags),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .ram_address_0(ram_address_0), .ram_chip_enable_0(ram_chip_enable_0),
    .ram_write_read_0(ram_write_read_0), .ram_data_0(ram_data_0),
    .ram_address_1(ram_address_1), .ram_chip_enable_1(ram_chip_enable_1),
    .ram_write_read_1(ram_write_read_1), .ram_data_1(ram_data_1),
    .ram_full(ram_full)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered read and read-before-write behaviour.
  logic [DW-1:0] mem [DEPTH];
  initial ram_data_1 = '0;
  always @(posedge clk) begin
    if (ram_chip_enable_1) ram_data_1 <= mem[ram_address_1];
    if (ram_chip_enable_0) mem[ram_address_0] <= ram_data_0;
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];     // model FIFO contents
  logic [DW-1:0] exp_q[$];  // scoreboard: expected read data
  logic          m_ov = 1'b0;
  logic          m_un = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status();
    int c;
    c = mq.size();
    check("count", 32'(count), 32'(c));
    check("full", 32'(full), 32'(c == DEPTH));
    check("empty", 32'(empty), 32'(c == 0));
    check("almost_full", 32'(almost_full), 32'(c >= DEPTH - 2));
    check("almost_empty", 32'(almost_empty), 32'(c <= 2));
    check("ram_full", 32'(ram_full), 32'(c == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
  endtask

  // Called at posedge+1; drives one cycle of stimulus and checks results.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic c);
    logic pop_ok, push_ok, got_pop;
    wr_en = w; wr_data = d; rd_en = r; flush = f; clr_flags = c;
    pop_ok  = r && !f && (mq.size() > 0);
    push_ok = w && !f && ((mq.size() < DEPTH) || pop_ok);
    #1;
    check("ram_ce0", 32'(ram_chip_enable_0), 32'(push_ok));
    check("ram_ce1", 32'(ram_chip_enable_1), 32'(pop_ok));
    check("ram_dir0", 32'(ram_write_read_0), 32'd1);
    check("ram_dir1", 32'(ram_write_read_1), 32'd0);
    // Model update: pop before push so full push+pop behaves correctly.
    if (f) mq.delete();
    if (pop_ok) exp_q.push_back(mq.pop_front());
    if (push_ok) mq.push_back(d);
    if (w && !push_ok && !f) m_ov = 1'b1; else if (c) m_ov = 1'b0;
    if (r && !f && !pop_ok)  m_un = 1'b1; else if (c) m_un = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_flags = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'(pop_ok));
    got_pop = rd_valid;
    if (got_pop) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
      else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
    check_status();
  endtask

  task automatic push(input logic [DW-1:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic pop();                        step(1'b0, '0, 1'b1, 1'b0, 1'b0); endtask
  task automatic clr();                        step(1'b0, '0, 1'b0, 1'b0, 1'b1); endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_flags = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_status();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to full, then overflow, clear.
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i));
    push(8'h99);
    clr();
    // Clear coinciding with a new overflow: set wins.
    step(1'b1, 8'h98, 1'b0, 1'b0, 1'b1);
    clr();

    // Drain in order, then underflow.
    for (int i = 0; i < DEPTH; i++) pop();
    pop();
    clr();

    // Full with simultaneous push+pop, then drain (pointers wrap).
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i));
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) pop();

    // Empty with push+pop: push accepted, pop rejected.
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    pop();
    clr();

    // Flush overrides a push.
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    push(8'h33);
    push(8'h34);
    pop();
    pop();

    // Asynchronous reset with a pop result in flight.
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i));
    pop();
    pop();
    rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    rd_en = 1'b0;
    mq.delete(); exp_q.delete(); m_ov = 1'b0; m_un = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_status();
    push(8'hC3);
    pop();
    pop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
